// File: rtl/fifo_wr_feeder_if.sv
// rtl/fifo_wr_feeder_if.sv - producer stream and FIFO write-port bundle for fifo_wr_feeder
interface fifo_wr_feeder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             full;
   logic             overflow;
   logic             wr_en;
   logic [WIDTH-1:0] wdata;

   // master: the surroundings (producer plus FIFO flags) that drive the feeder
   modport master (
      output in_valid, in_data, full, overflow,
      input  in_ready, wr_en, wdata
   );

   // slave: the feeder itself
   modport slave (
      input  in_valid, in_data, full, overflow,
      output in_ready, wr_en, wdata
   );
endinterface

// File: rtl/fifo_wr_feeder.sv
// rtl/fifo_wr_feeder.sv - two-entry skid feeder for an async FIFO write port with statistics
module fifo_wr_feeder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic               wr_clk,
   input  logic               res,
   fifo_wr_feeder_if.slave    bus,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   wr_count,
   output logic [CNT_W-1:0]   stall_count,
   output logic               err_ovf
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] wr_count_q, wr_count_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             err_ovf_q, err_ovf_d;
   logic             ready;
   logic             pop;
   logic             acc;

   // Handshake, buffer bookkeeping and statistics next-state; clear beats increment
   always_comb begin
      ready         = (cnt_q != 2'd2) && !res;
      pop           = (cnt_q != 2'd0) && !bus.full && !res;
      acc           = bus.in_valid && ready;
      mem_d         = mem_q;
      head_d        = head_q;
      tail_d        = tail_q;
      wr_count_d    = wr_count_q;
      stall_count_d = stall_count_q;
      err_ovf_d     = err_ovf_q | bus.overflow;

      if (acc) begin
         mem_d[tail_q] = bus.in_data;
         tail_d        = ~tail_q;
      end
      if (pop) begin
         head_d = ~head_q;
      end
      cnt_d = cnt_q + 2'(acc) - 2'(pop);

      if (pop) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
      if ((cnt_q != 2'd0) && bus.full && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end

      if (clr_stats) begin
         wr_count_d    = '0;
         stall_count_d = '0;
         err_ovf_d     = 1'b0;
      end
   end

   // State registers; reset discards any buffered words
   always_ff @(posedge wr_clk) begin
      if (res) begin
         mem_q[0]      <= '0;
         mem_q[1]      <= '0;
         head_q        <= 1'b0;
         tail_q        <= 1'b0;
         cnt_q         <= 2'd0;
         wr_count_q    <= '0;
         stall_count_q <= '0;
         err_ovf_q     <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         cnt_q         <= cnt_d;
         wr_count_q    <= wr_count_d;
         stall_count_q <= stall_count_d;
         err_ovf_q     <= err_ovf_d;
      end
   end

   // wr_en is combinational on full so a rising full blocks the write in the same cycle
   assign bus.in_ready = ready;
   assign bus.wr_en    = pop;
   assign bus.wdata    = mem_q[head_q];
   assign wr_count     = wr_count_q;
   assign stall_count  = stall_count_q;
   assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// tb/tb_fifo_wr_feeder.sv - scoreboard testbench for fifo_wr_feeder (CNT_W 16 and 4 instances)
module tb_fifo_wr_feeder;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       full = 1'b0;
   logic       overflow = 1'b0;
   logic       clr = 1'b0;
   logic       toggle_full = 1'b0;
   logic       mon_en = 1'b0;

   logic [15:0] wr_count_a, stall_a;
   logic [3:0]  wr_count_b, stall_b;
   logic        err_a, err_b;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_wr_feeder_if #(.WIDTH(8)) bus_a ();
   fifo_wr_feeder_if #(.WIDTH(8)) bus_b ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_data  = in_data;
   assign bus_a.full     = full;
   assign bus_a.overflow = overflow;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_data  = in_data;
   assign bus_b.full     = full;
   assign bus_b.overflow = overflow;

   fifo_wr_feeder #(.WIDTH(8), .CNT_W(16)) dut_a (
      .wr_clk(clk), .res(res), .bus(bus_a), .clr_stats(clr),
      .wr_count(wr_count_a), .stall_count(stall_a), .err_ovf(err_a)
   );

   fifo_wr_feeder #(.WIDTH(8), .CNT_W(4)) dut_b (
      .wr_clk(clk), .res(res), .bus(bus_b), .clr_stats(clr),
      .wr_count(wr_count_b), .stall_count(stall_b), .err_ovf(err_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard / reference model, evaluated mid-cycle
   logic [7:0]  sb[$];
   logic [15:0] m_wr = 0, m_st = 0;
   logic [3:0]  m_wr4 = 0, m_st4 = 0;
   logic        m_err = 0;
   int          n_written = 0;
   int          run_len = 0, max_run = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         automatic logic exp_rdy = (sb.size() != 2) && !res;
         automatic logic exp_wen = (sb.size() != 0) && !full && !res;
         automatic logic stall   = (sb.size() != 0) && full;
         automatic logic [7:0] w;
         check_eq("in_ready", bus_a.in_ready, exp_rdy);
         check_eq("wr_en", bus_a.wr_en, exp_wen);
         check_eq("wr_en_b", bus_b.wr_en, exp_wen);
         check_eq("wr_count", wr_count_a, m_wr);
         check_eq("stall_count", stall_a, m_st);
         check_eq("err_ovf", err_a, m_err);
         check_eq("wr_count_b", wr_count_b, m_wr4);
         check_eq("stall_count_b", stall_b, m_st4);
         check_eq("err_ovf_b", err_b, m_err);
         if (exp_wen) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (res) begin
            sb.delete();
            m_wr = 0; m_st = 0; m_wr4 = 0; m_st4 = 0; m_err = 0;
         end else begin
            if (exp_wen) begin
               w = sb.pop_front();
               check_eq("wdata", bus_a.wdata, w);
               n_written++;
            end
            if (in_valid && exp_rdy) sb.push_back(in_data);
            if (clr) begin
               m_wr = 0; m_st = 0; m_wr4 = 0; m_st4 = 0; m_err = 0;
            end else begin
               if (exp_wen) begin
                  m_wr  = m_wr + 1;
                  m_wr4 = m_wr4 + 1;
               end
               if (stall && m_st != 16'hFFFF) m_st = m_st + 1;
               if (stall && m_st4 != 4'hF) m_st4 = m_st4 + 1;
               if (overflow) m_err = 1'b1;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (toggle_full) full = ~full;
   endtask

   task automatic push_word(input logic [7:0] d);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 200 && !done; t++) begin
         done = bus_a.in_ready;
         cyc();
      end
      in_valid = 1'b0;
      if (!done) check_eq("push_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      // reset
      cyc(); cyc();
      mon_en = 1'b1;
      #1;
      check_eq("rst_in_ready", bus_a.in_ready, 0);
      check_eq("rst_wr_en", bus_a.wr_en, 0);
      check_eq("rst_wdata", bus_a.wdata, 0);
      check_eq("rst_wr_count", wr_count_a, 0);
      check_eq("rst_err", err_a, 0);
      cyc();
      res = 1'b0;
      #1;
      check_eq("rdy_after_rst", bus_a.in_ready, 1);

      // stream 0x01..0x10
      for (int i = 1; i <= 16; i++) push_word(8'(i));
      repeat (4) cyc();
      check_eq("stream_wr_count", wr_count_a, 16);
      check_eq("stream_run", max_run, 16);

      // backpressure with one word held
      clr = 1'b1;
      push_word(8'h21);
      clr = 1'b0;
      full = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h22;
      cyc();
      in_data = 8'h23;
      check_eq("bp_rdy_low", bus_a.in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_no_write", bus_a.wr_en, 0);
         cyc();
      end
      check_eq("bp_stall5", stall_a, 5);
      in_valid = 1'b0;
      full = 1'b0;
      repeat (4) cyc();
      check_eq("bp_wr_count", wr_count_a, 2);

      // random valid, full toggling every cycle
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      base = n_written;
      toggle_full = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 2) == 0) cyc();
         push_word(8'($urandom));
      end
      t = 0;
      while ((n_written - base) < 1000 && t < 5000) begin
         cyc();
         t++;
      end
      toggle_full = 1'b0;
      full = 1'b0;
      repeat (3) cyc();
      check_eq("rand_written", n_written - base, 1000);
      check_eq("rand_wr_count", wr_count_a, 1000);
      check_eq("rand_wr_count_b", wr_count_b, 8);

      // overflow sticky, then clear against a write
      overflow = 1'b1;
      cyc();
      overflow = 1'b0;
      check_eq("ovf_set", err_a, 1);
      repeat (3) cyc();
      check_eq("ovf_sticky", err_a, 1);
      push_word(8'h5A);
      clr = 1'b1;
      #1;
      check_eq("clr_with_wr", bus_a.wr_en, 1);
      cyc();
      clr = 1'b0;
      check_eq("clr_wr_count", wr_count_a, 0);
      check_eq("clr_err", err_a, 0);

      // reset with two words stuck behind full
      full = 1'b1;
      push_word(8'h11);
      push_word(8'h12);
      check_eq("mid_cnt2_rdy", bus_a.in_ready, 0);
      res = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h77;
      #1;
      check_eq("mid_rst_rdy", bus_a.in_ready, 0);
      check_eq("mid_rst_wen", bus_a.wr_en, 0);
      cyc();
      res = 1'b0;
      full = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("mid_after_wen", bus_a.wr_en, 0);
      check_eq("mid_after_wdata", bus_a.wdata, 0);
      push_word(8'hA5);
      #1;
      check_eq("mid_first_wen", bus_a.wr_en, 1);
      check_eq("mid_first_wdata", bus_a.wdata, 8'hA5);
      repeat (2) cyc();

      // counter limits on the 4-bit instance
      clr = 1'b1;
      full = 1'b1;
      push_word(8'h31);
      clr = 1'b0;
      repeat (20) cyc();
      check_eq("sat_stall_b", stall_b, 15);
      check_eq("sat_stall_a", stall_a, 20);
      full = 1'b0;
      repeat (2) cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
      repeat (3) cyc();
      check_eq("wrap_wr_b", wr_count_b, 0);
      check_eq("wrap_wr_a", wr_count_a, 16);

      repeat (2) cyc();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
